// File: rtl/polar_to_rect_if.sv
// Start/busy/done handshake and operand/result bus of the polar-to-rectangular CORDIC.
interface polar_to_rect_if #(
    parameter int INPUTBITSIZE  = 13,
    parameter int OUTPUTBITSIZE = 19
);
    logic                            start;
    logic                            busy;
    logic                            done;
    logic signed [INPUTBITSIZE-1:0]  mag;
    logic signed [OUTPUTBITSIZE-1:0] angle;
    logic signed [INPUTBITSIZE-1:0]  x;
    logic signed [INPUTBITSIZE-1:0]  y;

    modport master (output start, mag, angle, input busy, done, x, y);
    modport slave  (input start, mag, angle, output busy, done, x, y);
endinterface

// File: rtl/polar_to_rect.sv
// Iterative rotation-mode CORDIC: (mag, angle in deg*2^10) -> (x, y), one micro-rotation per clock.
module polar_to_rect #(
    parameter int INPUTBITSIZE  = 13,
    parameter int OUTPUTBITSIZE = 19,
    parameter int NITER         = 16,
    parameter int GUARD         = 4
) (
    input  logic            clock,
    input  logic            reset,
    polar_to_rect_if.slave  bus
);
    localparam int IB = INPUTBITSIZE;
    localparam int OB = OUTPUTBITSIZE;
    localparam int XW = IB + GUARD + 2;
    localparam int ZW = OB + 1;
    localparam int CW = 5;

    localparam logic signed [OB-1:0] ANG_180  = OB'(184320);
    localparam logic signed [OB-1:0] ANG_90   = OB'(92160);
    localparam logic signed [XW-1:0] HALF_LSB = XW'(1 << (GUARD - 1));
    localparam logic signed [XW-1:0] SAT_MAX  = XW'((1 << (IB - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN  = XW'(-(1 << (IB - 1)));

    typedef enum logic [1:0] {IDLE, LOAD, ROT, OUT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [IB-1:0]   mag_q, mag_d;
    logic signed [OB-1:0]   ang_q, ang_d;
    logic signed [XW-1:0]   xr_q, xr_d, yr_q, yr_d;
    logic signed [ZW-1:0]   zr_q, zr_d;
    logic signed [IB-1:0]   x_q, x_d, y_q, y_d;
    logic                   done_q, done_d;

    logic signed [OB-1:0]   a_c;
    logic signed [XW-1:0]   m_c, xs_c, ys_c;

    function automatic logic signed [OB-1:0] clamp_angle(input logic signed [OB-1:0] a);
        if (a > ANG_180)       return ANG_180;
        else if (a < -ANG_180) return -ANG_180;
        else                   return a;
    endfunction

    // mag * 19898 / 2^15 (= 1/K) with GUARD fractional bits kept
    function automatic logic signed [XW-1:0] scale_mag(input logic signed [IB-1:0] m);
        logic signed [IB+15:0] me;
        logic signed [IB+15:0] p;
        me = {{16{m[IB-1]}}, m};
        p  = me * $signed((IB+16)'(19898));
        return XW'(p >>> (15 - GUARD));
    endfunction

    function automatic logic signed [IB-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] r;
        r = (v + HALF_LSB) >>> GUARD;
        if (r > SAT_MAX)      return IB'(SAT_MAX);
        else if (r < SAT_MIN) return IB'(SAT_MIN);
        else                  return IB'(r);
    endfunction

    function automatic logic signed [ZW-1:0] atan_tab(input logic [CW-1:0] i);
        case (i)
            5'd0:    return ZW'(46080);
            5'd1:    return ZW'(27203);
            5'd2:    return ZW'(14373);
            5'd3:    return ZW'(7296);
            5'd4:    return ZW'(3662);
            5'd5:    return ZW'(1833);
            5'd6:    return ZW'(917);
            5'd7:    return ZW'(458);
            5'd8:    return ZW'(229);
            5'd9:    return ZW'(115);
            5'd10:   return ZW'(57);
            5'd11:   return ZW'(29);
            5'd12:   return ZW'(14);
            5'd13:   return ZW'(7);
            5'd14:   return ZW'(4);
            5'd15:   return ZW'(2);
            5'd16:   return ZW'(1);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        a_c     = '0;
        m_c     = '0;
        xs_c    = '0;
        ys_c    = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d   = bus.mag;
                    ang_d   = bus.angle;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_c = clamp_angle(ang_q);
                m_c = scale_mag(mag_q);
                // Pre-rotate by +/-90 deg so the residual stays inside CORDIC convergence
                if (a_c > ANG_90) begin
                    xr_d = '0;
                    yr_d = m_c;
                    zr_d = ZW'(a_c) - ZW'(ANG_90);
                end else if (a_c < -ANG_90) begin
                    xr_d = '0;
                    yr_d = -m_c;
                    zr_d = ZW'(a_c) + ZW'(ANG_90);
                end else begin
                    xr_d = m_c;
                    yr_d = '0;
                    zr_d = ZW'(a_c);
                end
                cnt_d   = '0;
                state_d = ROT;
            end
            ROT: begin
                xs_c = xr_q >>> cnt_q;
                ys_c = yr_q >>> cnt_q;
                if (!zr_q[ZW-1]) begin
                    xr_d = xr_q - ys_c;
                    yr_d = yr_q + xs_c;
                    zr_d = zr_q - atan_tab(cnt_q);
                end else begin
                    xr_d = xr_q + ys_c;
                    yr_d = yr_q - xs_c;
                    zr_d = zr_q + atan_tab(cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NITER - 1)) state_d = OUT;
            end
            OUT: begin
                x_d     = round_sat(xr_q);
                y_d     = round_sat(yr_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            ang_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.x    = x_q;
    assign bus.y    = y_q;

endmodule
